univ_shift_reg: RTL and testbench

//  Command-driven universal shift register. Consumes the parallel load word and

---
 rtl/univ_shift_reg_pkg.sv | 40 ++++
 rtl/univ_shift_reg_if.sv | 49 ++++
 rtl/univ_shift_reg_dp.sv | 56 +++++
 rtl/univ_shift_reg.sv | 127 ++++++++++++
 tb/tb_univ_shift_reg.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/univ_shift_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : univ_shift_pkg
// Purpose  : Shared encodings for the universal shift register. This covers
//            the command opcodes, the FSM states and a helper that classifies
//            opcodes.
// Ports    : none (package)
// Config   : MATCH_DETECT_EN is not used here
// Revision : 1.0 - initial release
// ============================================================================
package univ_shift_pkg;

  // Command opcodes. Codes 6 and 7 are reserved and execute as HOLD.
  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_LOAD = 3'd1,
    OP_SHR  = 3'd2,
    OP_SHL  = 3'd3,
    OP_ROTR = 3'd4,
    OP_ROTL = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Opcodes that step once per edge, for as many edges as the command count.
  function automatic logic is_shift_op(input logic [2:0] op);
    logic r;
    case (op)
      OP_SHR, OP_SHL, OP_ROTR, OP_ROTL: r = 1'b1;
      default:                          r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/univ_shift_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : univ_shift_reg_if
// Purpose  : Command / data bundle between the pattern generator (master)
//            and the universal shift register (slave).
// Signals  : cmd_valid, cmd_ready, cmd_op[2:0], cmd_cnt[CNT_W-1:0],
//            par_in[WIDTH-1:0], ser_in, q[WIDTH-1:0], ser_out, busy, done
//            and, with MATCH_DETECT_EN, match_pat[WIDTH-1:0] and match.
// Config   : MATCH_DETECT_EN adds the match_pat and match signals.
// Revision : 1.0 - initial release
// ============================================================================
interface univ_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic [WIDTH-1:0] par_in;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic             ser_out;
  logic             busy;
  logic             done;
`ifdef MATCH_DETECT_EN
  logic [WIDTH-1:0] match_pat;
  logic             match;

  modport master (
    output cmd_valid, cmd_op, cmd_cnt, par_in, ser_in, match_pat,
    input  cmd_ready, q, ser_out, busy, done, match
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_cnt, par_in, ser_in, match_pat,
    output cmd_ready, q, ser_out, busy, done, match
  );
`else
  modport master (
    output cmd_valid, cmd_op, cmd_cnt, par_in, ser_in,
    input  cmd_ready, q, ser_out, busy, done
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_cnt, par_in, ser_in,
    output cmd_ready, q, ser_out, busy, done
  );
`endif
endinterface
`default_nettype wire

// File: rtl/univ_shift_reg_dp.sv
`default_nettype none
// ============================================================================
// Module   : univ_shift_dp
// Purpose  : Combinational single-step datapath. Given the current register
//            value, it produces the next register value and the next serial
//            output for one opcode.
// Ports    : i_op[2:0], i_q[WIDTH-1:0], i_ser_cur, i_ser_in,
//            i_par[WIDTH-1:0] -> o_q_nxt[WIDTH-1:0], o_ser_nxt
// Config   : MATCH_DETECT_EN is not used here
// Revision : 1.0 - initial release
// ============================================================================
module univ_shift_dp
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  wire logic [2:0]       i_op,
  input  wire logic [WIDTH-1:0] i_q,
  input  wire logic             i_ser_cur,
  input  wire logic             i_ser_in,
  input  wire logic [WIDTH-1:0] i_par,
  output logic      [WIDTH-1:0] o_q_nxt,
  output logic                  o_ser_nxt
);

  always_comb begin
    o_q_nxt   = i_q;
    o_ser_nxt = i_ser_cur;
    case (i_op)
      OP_LOAD: o_q_nxt = i_par;
      OP_SHR: begin
        o_q_nxt   = {i_ser_in, i_q[WIDTH-1:1]};
        o_ser_nxt = i_q[0];
      end
      OP_SHL: begin
        o_q_nxt   = {i_q[WIDTH-2:0], i_ser_in};
        o_ser_nxt = i_q[WIDTH-1];
      end
      // Rotates re-inject the leaving bit, which is also reported on ser_out.
      OP_ROTR: begin
        o_q_nxt   = {i_q[0], i_q[WIDTH-1:1]};
        o_ser_nxt = i_q[0];
      end
      OP_ROTL: begin
        o_q_nxt   = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
        o_ser_nxt = i_q[WIDTH-1];
      end
      default: begin
        o_q_nxt   = i_q;
        o_ser_nxt = i_ser_cur;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : univ_shift_reg
// Purpose  : Command-driven universal shift register. It supports hold, load,
//            shift right and left, and rotate right and left, each with a
//            programmable step count. Completion is reported with a
//            one-cycle done pulse.
// Ports    : clk, rst (sync, active-high), bus (univ_shift_reg_if.slave):
//            cmd_valid/cmd_ready handshake, cmd_op, cmd_cnt, par_in, ser_in
//            -> q, ser_out, busy, done [, match_pat -> match]
// Config   : MATCH_DETECT_EN adds a registered compare of q against match_pat.
// Revision : 1.0 - initial release
// ============================================================================
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input wire logic         clk,
  input wire logic         rst,
  univ_shift_reg_if.slave  bus
);

  state_e           state_q, state_d;
  logic [2:0]       op_q,    op_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] par_q,   par_d;
  logic [WIDTH-1:0] sr_q,    sr_d;
  logic             ser_q,   ser_d;

  logic [WIDTH-1:0] w_dp_q;
  logic             w_dp_ser;

  univ_shift_dp #(.WIDTH(WIDTH)) u_dp (
    .i_op      (op_q),
    .i_q       (sr_q),
    .i_ser_cur (ser_q),
    .i_ser_in  (bus.ser_in),
    .i_par     (par_q),
    .o_q_nxt   (w_dp_q),
    .o_ser_nxt (w_dp_ser)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    sr_d    = sr_q;
    ser_d   = ser_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          state_d = ST_EXEC;
          op_d    = bus.cmd_op;
          cnt_d   = bus.cmd_cnt;
          par_d   = bus.par_in;
        end
      end
      ST_EXEC: begin
        if (op_q == OP_LOAD) begin
          sr_d    = w_dp_q;
          state_d = ST_DONE;
        end else if (is_shift_op(op_q) && (cnt_q != '0)) begin
          // One step per edge. The edge that performs the last step moves to DONE.
          sr_d  = w_dp_q;
          ser_d = w_dp_ser;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end else begin
          // HOLD, reserved opcodes and zero-count shifts complete immediately.
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      par_q   <= '0;
      sr_q    <= '0;
      ser_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      sr_q    <= sr_d;
      ser_q   <= ser_d;
    end
  end

  assign bus.q         = sr_q;
  assign bus.ser_out   = ser_q;
  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);

`ifdef MATCH_DETECT_EN
  logic match_q, match_d;

  // The compare is registered, so match follows a change of q by one cycle.
  always_comb begin
    match_d = (sr_q == bus.match_pat);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_d;
    end
  end

  assign bus.match = match_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_univ_shift_reg
// Purpose  : Directed, table-driven testbench for univ_shift_reg, with
//            hand-written sequences for the multi-cycle corner cases.
// Config   : MATCH_DETECT_EN enables the match-detect sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_univ_shift_reg;
  import univ_shift_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  univ_shift_reg_if #(.WIDTH(8), .CNT_W(4)) bus ();

  univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0] op;
    logic [3:0] cnt;
    logic [7:0] par;
    logic       ser;
    logic [7:0] exp_q;
    logic       exp_ser;
    int         exp_lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Issue one command, wait for done and check the result, latency and handshake.
  // This task is entered and left at a falling edge.
  task automatic run_cmd(input logic [2:0] op, input logic [3:0] cnt, input logic [7:0] par,
                         input logic ser, input logic [7:0] eq, input logic eser,
                         input int elat, input string nm);
    int   guard = 0;
    int   lat   = 0;
    logic bz_ok = 1'b1;
    while (bus.cmd_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({nm, " ready_before"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_cnt   = cnt;
    bus.par_in    = par;
    bus.ser_in    = ser;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) bz_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (bus.busy !== 1'b1) bz_ok = 1'b0;
    check({nm, " latency"}, 32'(lat), 32'(elat));
    check({nm, " q"}, 32'(bus.q), 32'(eq));
    check({nm, " ser_out"}, 32'(bus.ser_out), 32'(eser));
    check({nm, " busy_ready_during"}, 32'(bz_ok), 32'd1);
    @(negedge clk);
    check({nm, " done_ready_after"}, {30'd0, bus.done, bus.cmd_ready}, 32'b01);
  endtask

  initial begin
    vecs[0]  = '{3'd1, 4'd0,  8'hAA, 1'b0, 8'hAA, 1'b0, 1};
    vecs[1]  = '{3'd2, 4'd1,  8'h00, 1'b0, 8'h55, 1'b0, 1};
    vecs[2]  = '{3'd3, 4'd1,  8'h00, 1'b1, 8'hAB, 1'b0, 1};
    vecs[3]  = '{3'd1, 4'd0,  8'h81, 1'b0, 8'h81, 1'b0, 1};
    vecs[4]  = '{3'd4, 4'd8,  8'h00, 1'b0, 8'h81, 1'b1, 8};
    vecs[5]  = '{3'd1, 4'd0,  8'hF0, 1'b0, 8'hF0, 1'b1, 1};
    vecs[6]  = '{3'd2, 4'd0,  8'h00, 1'b1, 8'hF0, 1'b1, 1};
    vecs[7]  = '{3'd7, 4'd3,  8'h00, 1'b1, 8'hF0, 1'b1, 1};
    vecs[8]  = '{3'd3, 4'd3,  8'h00, 1'b0, 8'h80, 1'b1, 3};
    vecs[9]  = '{3'd2, 4'd4,  8'h00, 1'b1, 8'hF8, 1'b0, 4};
    vecs[10] = '{3'd5, 4'd3,  8'h00, 1'b0, 8'hC7, 1'b1, 3};
    vecs[11] = '{3'd0, 4'd5,  8'h00, 1'b0, 8'hC7, 1'b1, 1};
    vecs[12] = '{3'd2, 4'd15, 8'h00, 1'b0, 8'h00, 1'b0, 15};
    vecs[13] = '{3'd1, 4'd0,  8'h3C, 1'b0, 8'h3C, 1'b0, 1};
    vecs[14] = '{3'd4, 4'd2,  8'h00, 1'b1, 8'h0F, 1'b0, 2};
    vecs[15] = '{3'd5, 4'd1,  8'h00, 1'b0, 8'h1E, 1'b0, 1};

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_cnt   = 4'd0;
    bus.par_in    = 8'h00;
    bus.ser_in    = 1'b0;
`ifdef MATCH_DETECT_EN
    bus.match_pat = 8'h55;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("reset q", 32'(bus.q), 32'h00);
    check("reset flags", {27'd0, bus.ser_out, bus.busy, bus.done, bus.cmd_ready, 1'b0}, 32'b00010);
`ifdef MATCH_DETECT_EN
    check("reset match", 32'(bus.match), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      run_cmd(vecs[i].op, vecs[i].cnt, vecs[i].par, vecs[i].ser,
              vecs[i].exp_q, vecs[i].exp_ser, vecs[i].exp_lat, $sformatf("vec%0d", i));
    end

    // A second command held on cmd_valid during EXEC is taken only once ready returns.
    // q=0x1E. SHL cnt=2 ser_in=0 gives 0x3C then 0x78. The held LOAD 0x5A follows.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd3;
    bus.cmd_cnt   = 4'd2;
    bus.ser_in    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_op  = 3'd1;
    bus.cmd_cnt = 4'd0;
    bus.par_in  = 8'h5A;
    check("held ready_low_E0", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    check("held q_E1", 32'(bus.q), 32'h3C);
    @(negedge clk);
    check("held done_E2", {bus.done, bus.q}, {1'b1, 8'h78});
    @(negedge clk);
    check("held ready_E3", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("held accepted_E4", {bus.busy, bus.q}, {1'b1, 8'h78});
    @(negedge clk);
    check("held load_E5", {bus.done, bus.q}, {1'b1, 8'h5A});
    @(negedge clk);

    // Reset during a shift aborts it. From 0x5A, SHL cnt=5 ser_in=1 gives 0xB5
    // then 0x6B, after which rst lands on the third step edge.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd3;
    bus.cmd_cnt   = 4'd5;
    bus.ser_in    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_op = 3'd1;
    bus.par_in = 8'hFF;
    @(negedge clk);
    check("abort q_E1", {bus.cmd_ready, bus.q}, {1'b0, 8'hB5});
    @(negedge clk);
    check("abort q_E2", {bus.cmd_ready, bus.q}, {1'b0, 8'h6B});
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("abort q_after_rst", 32'(bus.q), 32'h00);
    check("abort flags_after_rst", {28'd0, bus.ser_out, bus.busy, bus.done, bus.cmd_ready}, 32'b0001);
    rst = 1'b0;
    begin
      logic seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (bus.done === 1'b1) seen = 1'b1;
      end
      check("abort no_done", 32'(seen), 32'd0);
    end

`ifdef MATCH_DETECT_EN
    // LOAD 0xAA, then SHR cnt=1 ser_in=0 yields 0x55, and match rises one cycle later.
    run_cmd(3'd1, 4'd0, 8'hAA, 1'b0, 8'hAA, 1'b0, 1, "match_load");
    check("match low_on_AA", 32'(bus.match), 32'd0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd2;
    bus.cmd_cnt   = 4'd1;
    bus.ser_in    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("match q_is_55", {bus.q, bus.match}, {8'h55, 1'b0});
    @(negedge clk);
    check("match high", 32'(bus.match), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  // A hang anywhere above still reaches the summary line.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: got no finish expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
